// File: rtl/spi_master_ctrl.sv
// SPI master that serialises 10-bit host commands onto SS_n/MOSI on the system clock
// and captures an 8-bit MISO response for read-data commands.
module spi_master_ctrl #(
  parameter int FRAME_BITS = 10,
  parameter int RD_START   = 14,
  parameter int RD_BITS    = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  input  logic [FRAME_BITS-1:0] cmd_data,
  output logic                  cmd_ready,
  output logic [RD_BITS-1:0]    rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  SS_n,
  output logic                  MOSI,
  input  logic                  MISO
);

  localparam int KW = $clog2(RD_START + RD_BITS + GAP_CYCLES + 1);

  localparam logic [KW-1:0] K_ONE        = KW'(1);
  localparam logic [KW-1:0] K_SHIFT_LAST = KW'(FRAME_BITS + 1);
  localparam logic [KW-1:0] K_RD_FIRST   = KW'(RD_START);
  localparam logic [KW-1:0] K_RD_LAST    = KW'(RD_START + RD_BITS - 1);
  localparam logic [KW-1:0] K_GAP_LAST   = KW'(GAP_CYCLES - 1);
  localparam logic [1:0]    OP_RD_DATA   = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEL    = 3'd1,
    CMD    = 3'd2,
    SHIFT  = 3'd3,
    TAIL   = 3'd4,
    RDWAIT = 3'd5,
    READ   = 3'd6,
    GAP    = 3'd7
  } state_t;

  state_t                state_r, state_s;
  logic [KW-1:0]         k_r, k_s;
  logic [KW-1:0]         k_inc_s;
  logic [FRAME_BITS-1:0] sh_r, sh_s;
  logic [1:0]            op_r, op_s;
  logic [RD_BITS-1:0]    rx_r, rx_s;
  logic [RD_BITS-1:0]    rd_data_s;
  logic                  rd_valid_s;
  logic                  ss_n_s;
  logic                  mosi_s;
  logic                  busy_s;
  logic                  cmd_ready_s;

  assign k_inc_s = k_r + K_ONE;

  // Next-state, frame counter and shift-register update.
  always_comb begin
    state_s = state_r;
    k_s     = k_inc_s;
    sh_s    = sh_r;
    op_s    = op_r;
    rx_s    = rx_r;
    case (state_r)
      IDLE: begin
        k_s = '0;
        if (cmd_valid && cmd_ready) begin
          state_s = SEL;
          sh_s    = cmd_data;
          op_s    = cmd_data[FRAME_BITS-1 -: 2];
        end else begin
          state_s = IDLE;
        end
      end
      SEL: begin
        state_s = CMD;
      end
      CMD: begin
        // The select bit and the first SHIFT bit are both cmd_data MSB, so no shift yet.
        state_s = SHIFT;
      end
      SHIFT: begin
        sh_s = {sh_r[FRAME_BITS-2:0], 1'b0};
        if (k_r == K_SHIFT_LAST) begin
          state_s = TAIL;
        end else begin
          state_s = SHIFT;
        end
      end
      TAIL: begin
        if (op_r == OP_RD_DATA) begin
          if (k_inc_s == K_RD_FIRST) begin
            state_s = READ;
          end else begin
            state_s = RDWAIT;
          end
        end else begin
          state_s = GAP;
          k_s     = '0;
        end
      end
      RDWAIT: begin
        if (k_inc_s == K_RD_FIRST) begin
          state_s = READ;
        end else begin
          state_s = RDWAIT;
        end
      end
      READ: begin
        rx_s = {rx_r[RD_BITS-2:0], MISO};
        if (k_r == K_RD_LAST) begin
          state_s = GAP;
          k_s     = '0;
        end else begin
          state_s = READ;
        end
      end
      GAP: begin
        if (k_r == K_GAP_LAST) begin
          state_s = IDLE;
          k_s     = '0;
        end else begin
          state_s = GAP;
        end
      end
      default: begin
        state_s = IDLE;
        k_s     = '0;
      end
    endcase
  end

  // Output values for the upcoming cycle, derived from the next state so the pins are registered.
  always_comb begin
    ss_n_s      = 1'b1;
    mosi_s      = 1'b0;
    busy_s      = 1'b1;
    cmd_ready_s = 1'b0;
    rd_valid_s  = 1'b0;
    rd_data_s   = rd_data;
    case (state_s)
      IDLE: begin
        busy_s      = 1'b0;
        cmd_ready_s = 1'b1;
      end
      GAP: begin
        ss_n_s = 1'b1;
      end
      CMD, SHIFT: begin
        ss_n_s = 1'b0;
        mosi_s = sh_s[FRAME_BITS-1];
      end
      SEL, TAIL, RDWAIT, READ: begin
        ss_n_s = 1'b0;
      end
      default: begin
        ss_n_s = 1'b1;
      end
    endcase
    if ((state_r == READ) && (k_r == K_RD_LAST)) begin
      rd_valid_s = 1'b1;
      rd_data_s  = rx_s;
    end else begin
      rd_valid_s = 1'b0;
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      k_r     <= '0;
      sh_r    <= '0;
      op_r    <= 2'b00;
      rx_r    <= '0;
    end else begin
      state_r <= state_s;
      k_r     <= k_s;
      sh_r    <= sh_s;
      op_r    <= op_s;
      rx_r    <= rx_s;
    end
  end

  // Registered host and SPI outputs; reset forces SS_n high immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      SS_n      <= ss_n_s;
      MOSI      <= mosi_s;
      cmd_ready <= cmd_ready_s;
      busy      <= busy_s;
      rd_valid  <= rd_valid_s;
      rd_data   <= rd_data_s;
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: stimulus queues expected frames, a negedge
// monitor plays the SPI slave and checks each frame, gap and read response.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [9:0] cmd_data = 10'h000;
  logic       cmd_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO = 1'b0;

  spi_master_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] cmd;
    logic [7:0] miso;
  } frame_t;

  frame_t exp_q[$];
  int     fall_q[$];
  int     compared = 0;
  int     mismatched = 0;

  int       cyc = 0;
  int       mon_k = 0;
  int       gap_k = -1;
  bit       in_frame = 1'b0;
  logic     prev_ss = 1'b1;
  logic [7:0]  last_rd = 8'h00;
  logic [31:0] got_bits = 32'h0;
  frame_t   cur = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic int exp_len(input logic [9:0] c);
    return (c[9:8] == 2'b11) ? 22 : 13;
  endfunction

  function automatic logic [31:0] exp_mosi(input logic [9:0] c);
    logic [31:0] v;
    v = 32'h0;
    v[1] = c[9];
    for (int k = 2; k <= 11; k++) v[k] = c[11-k];
    return v;
  endfunction

  // Monitor and slave model: everything sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      in_frame = 1'b0;
      prev_ss  = 1'b1;
      gap_k    = -1;
      last_rd  = 8'h00;
      MISO     = 1'b0;
    end else begin
      chk("ready_vs_busy", {31'h0, cmd_ready}, {31'h0, ~busy});
      if (SS_n) chk("mosi_idle_zero", {31'h0, MOSI}, 32'h0);
      if (gap_k >= 0) begin
        gap_k++;
        if (gap_k < 2) begin
          chk("gap_ready_low", {31'h0, cmd_ready}, 32'h0);
        end else begin
          chk("gap_ready_rise", {31'h0, cmd_ready}, 32'h1);
          gap_k = -1;
        end
      end
      if (!SS_n) begin
        if (prev_ss) begin
          if (exp_q.size() == 0) begin
            fail("unexpected_frame");
            cur = '0;
          end else begin
            cur = exp_q.pop_front();
          end
          mon_k    = 0;
          in_frame = 1'b1;
          got_bits = 32'h0;
          fall_q.push_back(cyc);
        end else begin
          mon_k++;
        end
        if (mon_k < 32) got_bits[mon_k] = MOSI;
        if (rd_valid) fail("rd_valid_in_frame");
        if (cur.cmd[9:8] == 2'b11 && mon_k >= 14 && mon_k < 22)
          MISO = cur.miso[7-(mon_k-14)];
        else
          MISO = 1'($urandom_range(0, 1));
      end else begin
        if (in_frame) begin
          chk("frame_len", 32'(mon_k + 1), 32'(exp_len(cur.cmd)));
          chk("mosi_stream", got_bits, exp_mosi(cur.cmd));
          if (cur.cmd[9:8] == 2'b11) begin
            chk("rd_valid_pulse", {31'h0, rd_valid}, 32'h1);
            chk("rd_data", {24'h0, rd_data}, {24'h0, cur.miso});
            last_rd = cur.miso;
          end else begin
            chk("no_rd_valid", {31'h0, rd_valid}, 32'h0);
            chk("rd_data_hold", {24'h0, rd_data}, {24'h0, last_rd});
          end
          chk("gap_ready_low", {31'h0, cmd_ready}, 32'h0);
          gap_k    = 0;
          in_frame = 1'b0;
        end else if (rd_valid) begin
          fail("unexpected_rd_valid");
        end
        MISO = 1'($urandom_range(0, 1));
      end
      prev_ss = SS_n;
    end
  end

  task automatic send(input logic [9:0] c, input logic [7:0] b);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_data  = c;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      fail("accept_timeout");
    end else begin
      exp_q.push_back('{cmd: c, miso: b});
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    #1;
    while (!(exp_q.size() == 0 && !in_frame && gap_k < 0 && cmd_ready) && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 400) fail("idle_timeout");
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ss_n"}, {31'h0, SS_n}, 32'h1);
    chk({tag, "_mosi"}, {31'h0, MOSI}, 32'h0);
    chk({tag, "_cmd_ready"}, {31'h0, cmd_ready}, 32'h1);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_rd_valid"}, {31'h0, rd_valid}, 32'h0);
    chk({tag, "_rd_data"}, {24'h0, rd_data}, 32'h0);
  endtask

  initial begin
    int n0;
    int n;
    repeat (3) @(negedge clk);
    chk_reset_vals("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("after_reset");

    // Directed write-address and read-data frames.
    send(10'b00_1010_0101, 8'h00);
    wait_idle();
    send(10'b11_0000_0000, 8'hC3);
    wait_idle();

    // Back-to-back: second command held valid until the first IDLE cycle.
    n0 = fall_q.size();
    send(10'b10_0001_0000, 8'h5A);
    send(10'b11_0000_0001, 8'h96);
    wait_idle();
    if (fall_q.size() >= n0 + 2)
      chk("b2b_period", 32'(fall_q[n0+1] - fall_q[n0]), 32'd16);
    else
      fail("b2b_frames_missing");

    // Busy rejection: a mid-frame command pulse must not be taken.
    send(10'b00_0011_1100, 8'h00);
    repeat (4) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = 10'b01_1111_1111;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle();

    // Reset during READ at k=17.
    send(10'b11_1010_1010, 8'hE7);
    n = 0;
    #1;
    while (!(in_frame && mon_k == 17) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) fail("k17_timeout");
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_ss_n", {31'h0, SS_n}, 32'h1);
    chk("async_reset_rd_valid", {31'h0, rd_valid}, 32'h0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk_reset_vals("post_abort");
    send(10'b01_0110_1001, 8'h00);
    wait_idle();
    send(10'b11_0101_0101, 8'h3C);
    wait_idle();

    // Randomised traffic with random host idle gaps.
    for (int i = 0; i < 24; i++) begin
      send(10'($urandom_range(0, 1023)), 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
